// File: rtl/instr_encoder_if.sv
// Request/response bundle for instr_encoder: valid/ready request side carrying the
// instruction fields, valid/ready response side carrying the packed word.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opc;
    logic        in_li;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_last;
    logic        out_err;

    modport master (
        output in_valid, in_opc, in_li, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
        output out_ready,
        input  in_ready, out_valid, out_instr, out_last, out_err
    );

    modport slave (
        input  in_valid, in_opc, in_li, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
        input  out_ready,
        output in_ready, out_valid, out_instr, out_last, out_err
    );
endinterface

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs fields and a full-width immediate into a registered
// instruction word, flags out-of-range immediates and expands li into LUI+ADDI.
//
// state     | meaning
// ST_IDLE   | accepting requests; output register holds at most one word
// ST_PEND   | LUI of a two-word li is presented, ADDI waits for its handshake
module instr_encoder (
    input  logic           clk,
    input  logic           rst_n,
    instr_encoder_if.slave bus
);
    localparam logic [6:0] OPC_R_TYPE = 7'b0110011;
    localparam logic [6:0] OPC_I_TYPE = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    logic [0:0]  state_q;
    logic        out_valid_q;
    logic [31:0] out_instr_q;
    logic        out_last_q;
    logic        out_err_q;
    logic [4:0]  li_rd_q;
    logic [11:0] li_lo_q;

    logic [31:0] imm;
    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        fits_i;
    logic        fits_b;
    logic        fits_j;
    logic        is_shift;
    logic [19:0] lui_hi;

    logic [31:0] first_word;
    logic        first_err;
    logic        first_last;
    logic        need_addi;
    logic        accept;
    logic        out_fire;

    assign imm = bus.in_imm;
    assign opc = bus.in_opc;
    assign rd  = bus.in_rd;
    assign rs1 = bus.in_rs1;
    assign rs2 = bus.in_rs2;
    assign f3  = bus.in_funct3;
    assign f7  = bus.in_funct7;

    // Sign-extension checks: every bit above the field's sign bit equals that sign bit.
    assign fits_i   = (imm[31:11] == '0) || (imm[31:11] == '1);
    assign fits_b   = (imm[31:12] == '0) || (imm[31:12] == '1);
    assign fits_j   = (imm[31:20] == '0) || (imm[31:20] == '1);
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    // Rounding the upper part compensates for ADDI sign-extending its low 12 bits.
    assign lui_hi = imm[31:12] + {19'd0, imm[11]};

    always_comb begin
        first_word = '0;
        first_err  = 1'b0;
        first_last = 1'b1;
        need_addi  = 1'b0;
        if (bus.in_li) begin
            if (fits_i) begin
                first_word = {imm[11:0], 5'd0, 3'b000, rd, OPC_I_TYPE};
            end else begin
                first_word = {lui_hi, rd, OPC_LUI};
                need_addi  = |imm[11:0];
                first_last = ~(|imm[11:0]);
            end
        end else begin
            case (opc)
                OPC_R_TYPE: begin
                    first_word = {f7, rs2, rs1, f3, rd, opc};
                end
                OPC_I_TYPE: begin
                    if (is_shift) begin
                        first_word = {f7, imm[4:0], rs1, f3, rd, opc};
                        first_err  = |imm[31:5];
                    end else begin
                        first_word = {imm[11:0], rs1, f3, rd, opc};
                        first_err  = ~fits_i;
                    end
                end
                OPC_LOAD, OPC_JALR: begin
                    first_word = {imm[11:0], rs1, f3, rd, opc};
                    first_err  = ~fits_i;
                end
                OPC_STORE: begin
                    first_word = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
                    first_err  = ~fits_i;
                end
                OPC_BRANCH: begin
                    first_word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
                    first_err  = ~fits_b | imm[0];
                end
                OPC_LUI, OPC_AUIPC: begin
                    first_word = {imm[31:12], rd, opc};
                    first_err  = |imm[11:0];
                end
                OPC_JAL: begin
                    first_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
                    first_err  = ~fits_j | imm[0];
                end
                default: begin
                    first_word = '0;
                    first_err  = 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign out_fire      = out_valid_q && bus.out_ready;

    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_err   = out_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_last_q  <= 1'b0;
            out_err_q   <= 1'b0;
            li_rd_q     <= '0;
            li_lo_q     <= '0;
        end else if (state_q == ST_PEND) begin
            if (out_fire) begin
                out_instr_q <= {li_lo_q, li_rd_q, 3'b000, li_rd_q, OPC_I_TYPE};
                out_last_q  <= 1'b1;
                out_err_q   <= 1'b0;
                state_q     <= ST_IDLE;
            end
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                out_instr_q <= first_word;
                out_last_q  <= first_last;
                out_err_q   <= first_err;
                if (need_addi) begin
                    li_rd_q <= rd;
                    li_lo_q <= imm[11:0];
                    state_q <= ST_PEND;
                end
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed literal cases, then randomized requests and
// backpressure checked every cycle against an arithmetic reference model.
module tb_instr_encoder;
    logic clk;
    logic rst_n;

    instr_encoder_if bus ();

    instr_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        li;
        bit [6:0]  opc;
        bit [4:0]  rd;
        bit [4:0]  rs1;
        bit [4:0]  rs2;
        bit [2:0]  f3;
        bit [6:0]  f7;
        bit [31:0] imm;
    } req_t;

    typedef struct {
        bit [31:0] w;
        bit        last;
        bit        err;
    } exp_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    bit   rnd_bp  = 0;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit fits(input bit [31:0] v, input int bits);
        longint s;
        longint lim;
        s   = longint'($signed(v));
        lim = longint'(1) << (bits - 1);
        return (s >= -lim) && (s < lim);
    endfunction

    // Reference: expected word(s) for one request, built from field positions with shifts.
    function automatic void expand(input req_t r, output exp_t o0, output exp_t o1, output int n);
        bit [31:0] base;
        bit [31:0] hi;
        bit [31:0] lo;
        o0 = '{w: 0, last: 1, err: 0};
        o1 = '{w: 0, last: 1, err: 0};
        n  = 1;
        base = 32'(r.opc) | (32'(r.rd) << 7) | (32'(r.f3) << 12) | (32'(r.rs1) << 15);
        if (r.li) begin
            if (fits(r.imm, 12)) begin
                o0.w = ((r.imm & 32'hFFF) << 20) | (32'(r.rd) << 7) | 32'h13;
            end else begin
                hi = (r.imm + 32'h800) >> 12;
                lo = r.imm & 32'hFFF;
                o0.w = (hi << 12) | (32'(r.rd) << 7) | 32'h37;
                if (lo != 0) begin
                    n = 2;
                    o0.last = 0;
                    o1.w = (lo << 20) | (32'(r.rd) << 15) | (32'(r.rd) << 7) | 32'h13;
                end
            end
        end else begin
            case (r.opc)
                7'b0110011: o0.w = base | (32'(r.rs2) << 20) | (32'(r.f7) << 25);
                7'b0010011: begin
                    if (r.f3 == 1 || r.f3 == 5) begin
                        o0.w   = base | ((r.imm & 31) << 20) | (32'(r.f7) << 25);
                        o0.err = (r.imm > 31);
                    end else begin
                        o0.w   = base | ((r.imm & 32'hFFF) << 20);
                        o0.err = !fits(r.imm, 12);
                    end
                end
                7'b0000011, 7'b1100111: begin
                    o0.w   = base | ((r.imm & 32'hFFF) << 20);
                    o0.err = !fits(r.imm, 12);
                end
                7'b0100011: begin
                    o0.w = 32'(r.opc) | ((r.imm & 31) << 7) | (32'(r.f3) << 12) | (32'(r.rs1) << 15)
                         | (32'(r.rs2) << 20) | (((r.imm >> 5) & 32'h7F) << 25);
                    o0.err = !fits(r.imm, 12);
                end
                7'b1100011: begin
                    o0.w = 32'(r.opc) | (((r.imm >> 11) & 1) << 7) | (((r.imm >> 1) & 15) << 8)
                         | (32'(r.f3) << 12) | (32'(r.rs1) << 15) | (32'(r.rs2) << 20)
                         | (((r.imm >> 5) & 32'h3F) << 25) | (((r.imm >> 12) & 1) << 31);
                    o0.err = !fits(r.imm, 13) || (r.imm % 2 != 0);
                end
                7'b0110111, 7'b0010111: begin
                    o0.w   = (r.imm & 32'hFFFFF000) | (32'(r.rd) << 7) | 32'(r.opc);
                    o0.err = (r.imm & 32'hFFF) != 0;
                end
                7'b1101111: begin
                    o0.w = 32'(r.opc) | (32'(r.rd) << 7) | (((r.imm >> 12) & 32'hFF) << 12)
                         | (((r.imm >> 11) & 1) << 20) | (((r.imm >> 1) & 32'h3FF) << 21)
                         | (((r.imm >> 20) & 1) << 31);
                    o0.err = !fits(r.imm, 21) || (r.imm % 2 != 0);
                end
                default: begin
                    o0.w   = 0;
                    o0.err = 1;
                end
            endcase
        end
    endfunction

    // Every-cycle compare against the model queue; sampled on the falling edge.
    always @(negedge clk) begin
        bit   exp_ready;
        req_t r;
        exp_t o0;
        exp_t o1;
        int   n;
        if (!rst_n) begin
            exp_q.delete();
            chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        end else begin
            exp_ready = ((exp_q.size() == 0) || exp_q[0].last) && (!bus.out_valid || bus.out_ready);
            chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
            chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
            if (bus.out_valid && exp_q.size() != 0) begin
                chk("out_instr", bus.out_instr, exp_q[0].w);
                chk("out_last", 32'(bus.out_last), 32'(exp_q[0].last));
                chk("out_err", 32'(bus.out_err), 32'(exp_q[0].err));
                if (bus.out_ready) void'(exp_q.pop_front());
            end
            if (bus.in_valid && bus.in_ready) begin
                r.li  = bus.in_li;
                r.opc = bus.in_opc;
                r.rd  = bus.in_rd;
                r.rs1 = bus.in_rs1;
                r.rs2 = bus.in_rs2;
                r.f3  = bus.in_funct3;
                r.f7  = bus.in_funct7;
                r.imm = bus.in_imm;
                expand(r, o0, o1, n);
                exp_q.push_back(o0);
                if (n == 2) exp_q.push_back(o1);
            end
        end
    end

    // Entered and left just after a rising edge; in_valid is left high on return.
    task automatic send(input req_t r);
        bit done;
        done = 0;
        bus.in_li     = r.li;
        bus.in_opc    = r.opc;
        bus.in_rd     = r.rd;
        bus.in_rs1    = r.rs1;
        bus.in_rs2    = r.rs2;
        bus.in_funct3 = r.f3;
        bus.in_funct7 = r.f7;
        bus.in_imm    = r.imm;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            done = bus.in_ready;
            @(posedge clk);
            #1;
            if (rnd_bp) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        chk("accept_in_time", 32'(done), 32'd1);
    endtask

    function automatic req_t mk(input bit li, input bit [6:0] opc, input bit [4:0] rd,
                                input bit [4:0] rs1, input bit [4:0] rs2, input bit [2:0] f3,
                                input bit [31:0] imm);
        req_t r;
        r.li = li; r.opc = opc; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
        r.f3 = f3; r.f7 = 7'd0; r.imm = imm;
        return r;
    endfunction

    task automatic expect_out(input string name, input logic [31:0] w, input bit last, input bit err);
        chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({name, "_instr"}, bus.out_instr, w);
        chk({name, "_last"}, 32'(bus.out_last), 32'(last));
        chk({name, "_err"}, 32'(bus.out_err), 32'(err));
    endtask

    bit [6:0] opcs [10];

    initial begin
        req_t r;
        exp_t o0;
        exp_t o1;
        int   n;
        int   mode;
        bit   drained;

        opcs = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1111111};

        // Pin the model to hand-computed encodings.
        expand(mk(0, 7'b0010011, 5, 1, 0, 0, 32'hFFFFFFFF), o0, o1, n);
        chk("model_addi", o0.w, 32'hFFF08293);
        expand(mk(1, 0, 10, 0, 0, 0, 32'h12345FFF), o0, o1, n);
        chk("model_li_lui", o0.w, 32'h12346537);
        chk("model_li_addi", o1.w, 32'hFFF50513);
        chk("model_li_n", 32'(n), 32'd2);
        expand(mk(0, 7'b1100011, 0, 1, 2, 0, 32'd8), o0, o1, n);
        chk("model_beq", o0.w, 32'h00208463);

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_li     = 1'b0;
        bus.in_opc    = '0;
        bus.in_rd     = '0;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.in_funct3 = '0;
        bus.in_funct7 = '0;
        bus.in_imm    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk("rst_out_instr", bus.out_instr, 32'd0);
        chk("rst_out_last", 32'(bus.out_last), 32'd0);
        chk("rst_out_err", 32'(bus.out_err), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;

        send(mk(0, 7'b0010011, 5, 1, 0, 0, 32'hFFFFFFFF));
        bus.in_valid = 1'b0;
        @(negedge clk); expect_out("addi", 32'hFFF08293, 1, 0);
        @(posedge clk); #1;

        send(mk(1, 0, 10, 0, 0, 0, 32'h12345FFF));
        bus.in_valid = 1'b0;
        @(negedge clk); expect_out("li_lui", 32'h12346537, 0, 0);
        chk("li_pend_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk); expect_out("li_addi", 32'hFFF50513, 1, 0);
        @(posedge clk); #1;

        send(mk(0, 7'b1100011, 0, 1, 2, 0, 32'd8));
        bus.in_valid = 1'b0;
        @(negedge clk); expect_out("beq", 32'h00208463, 1, 0);
        @(posedge clk); #1;
        send(mk(0, 7'b1100011, 0, 1, 2, 0, 32'd7));
        bus.in_valid = 1'b0;
        @(negedge clk); chk("beq_odd_err", 32'(bus.out_err), 32'd1);
        @(posedge clk); #1;

        send(mk(0, 7'b1101111, 1, 0, 0, 0, 32'h00100000));
        bus.in_valid = 1'b0;
        @(negedge clk); chk("jal_range_err", 32'(bus.out_err), 32'd1);
        @(posedge clk); #1;

        send(mk(1, 0, 3, 0, 0, 0, 32'h7FF));
        bus.in_valid = 1'b0;
        @(negedge clk); expect_out("li_small", 32'h7FF00193, 1, 0);
        @(posedge clk); #1;

        // Backpressure across a two-word li.
        bus.out_ready = 1'b0;
        send(mk(1, 0, 10, 0, 0, 0, 32'h12345FFF));
        bus.in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            expect_out("bp_lui_hold", 32'h12346537, 0, 0);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
        @(negedge clk); expect_out("bp_lui_release", 32'h12346537, 0, 0);
        @(negedge clk); expect_out("bp_addi", 32'hFFF50513, 1, 0);
        @(negedge clk); chk("bp_drained", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;

        // Asynchronous reset while the ADDI is pending.
        bus.out_ready = 1'b0;
        send(mk(1, 0, 10, 0, 0, 0, 32'h12345FFF));
        bus.in_valid = 1'b0;
        @(negedge clk); expect_out("pend_lui", 32'h12346537, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_instr", bus.out_instr, 32'd0);
        chk("async_rst_last", 32'(bus.out_last), 32'd0);
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("no_addi_after_rst", 32'(bus.out_valid), 32'd0);
        end
        @(posedge clk); #1;
        send(mk(0, 7'b0010011, 5, 1, 0, 0, 32'hFFFFFFFF));
        bus.in_valid = 1'b0;
        @(negedge clk); expect_out("post_rst_addi", 32'hFFF08293, 1, 0);
        @(posedge clk); #1;

        // Randomized requests with random backpressure and idle gaps.
        rnd_bp = 1;
        for (int k = 0; k < 400; k++) begin
            r.li  = ($urandom_range(0, 3) == 0);
            r.opc = opcs[$urandom_range(0, 9)];
            r.rd  = 5'($urandom);
            r.rs1 = 5'($urandom);
            r.rs2 = 5'($urandom);
            r.f3  = 3'($urandom);
            r.f7  = 7'($urandom);
            mode  = $urandom_range(0, 4);
            case (mode)
                0: r.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
                1: r.imm = $urandom;
                2: r.imm = $urandom & 32'hFFFFF000;
                3: r.imm = (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'd1;
                default: r.imm = 32'($urandom_range(0, 63));
            endcase
            send(r);
            if ($urandom_range(0, 4) == 0) begin
                bus.in_valid = 1'b0;
                @(posedge clk); #1;
                bus.out_ready = ($urandom_range(0, 3) != 0);
            end
        end
        bus.in_valid  = 1'b0;
        rnd_bp        = 0;
        bus.out_ready = 1'b1;
        drained = 0;
        for (int i = 0; i < 40 && !drained; i++) begin
            @(negedge clk);
            drained = (exp_q.size() == 0);
        end
        chk("drain", 32'(drained), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
